// File: rtl/kbd_spi_pkg.sv
// Shared definitions for the keyboard SPI link: widths common with the CPLD
// side, command address map and the host master FSM encoding.
package kbd_spi_pkg;

    localparam int KBD_ADR_WIDTH   = 3;
    localparam int KBD_COMM_WIDTH  = 8;
    localparam int KBD_REPLY_WIDTH = 8;

    localparam logic [KBD_ADR_WIDTH-1:0]  ADDR_FIFO     = 3'd1;
    localparam logic [KBD_ADR_WIDTH-1:0]  ADDR_CTRL     = 3'd4;
    localparam logic [KBD_COMM_WIDTH-1:0] FIFO_CLR_DATA = '0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    typedef enum logic {
        FRAME_HOST = 1'b0,
        FRAME_POLL = 1'b1
    } frame_kind_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCK generator: CLK_DIV clk cycles per half period, one-cycle rise/fall
// strobes aligned with the clk edge on which the sck level toggles.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic rise,
    output logic fall,
    output logic sck
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          sck_q;
    logic          wrap;

    assign wrap = (cnt == LAST);
    assign rise = en && wrap && !sck_q;
    assign fall = en && wrap && sck_q;
    assign sck  = sck_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            sck_q <= 1'b0;
        end else if (clr) begin
            cnt   <= '0;
            sck_q <= 1'b0;
        end else if (en) begin
            if (wrap) begin
                cnt   <= '0;
                sck_q <= !sck_q;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/kbd_spi_master.sv
// Host-side SPI master for the keyboard CPLD: serialises {addr, data}
// frames, captures the reply byte and optionally polls for key events.
module kbd_spi_master
    import kbd_spi_pkg::*;
#(
    parameter int ADR_WIDTH   = KBD_ADR_WIDTH,
    parameter int COMM_WIDTH  = KBD_COMM_WIDTH,
    parameter int REPLY_WIDTH = KBD_REPLY_WIDTH,
    parameter int CLK_DIV     = 4,
    parameter int GAP_CYCLES  = 8,
    parameter int POLL_PERIOD = 1000,
    parameter int POLL_ADDR   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADR_WIDTH-1:0]   cmd_addr,
    input  logic [COMM_WIDTH-1:0]  cmd_data,
    input  logic                   poll_en,
    output logic                   reply_valid,
    output logic [REPLY_WIDTH-1:0] reply_data,
    output logic                   ev_valid,
    output logic [REPLY_WIDTH-1:0] ev_code,
    output logic                   busy,
    output logic                   spi_sel,
    output logic                   spi_sck,
    output logic                   spi_mosi,
    input  logic                   spi_miso
);

    localparam int N  = ADR_WIDTH + COMM_WIDTH;
    localparam int BW = $clog2(N + 1);
    localparam int TW = $clog2(max_int(CLK_DIV, GAP_CYCLES) + 1);
    localparam int PW = $clog2(POLL_PERIOD + 1);

    localparam logic [TW-1:0] HALF_LAST   = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] GAP_LAST    = TW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_PERIOD);

    spi_state_e              state, state_nxt;
    frame_kind_e             kind;
    logic [TW-1:0]           tmr;
    logic [BW-1:0]           bit_cnt;
    logic [N-1:0]            shreg;
    logic [REPLY_WIDTH-1:0]  rx;
    logic [PW-1:0]           poll_cnt;
    logic                    poll_pend;
    logic                    init_done;
    logic                    start_host, start_poll, hold_done, gap_done;
    logic                    poll_due, in_frame;
    logic                    sck_rise, sck_fall, sck_lvl;

    // All interface outputs decode from async-reset flops, so an abort
    // releases sel and parks sck without waiting for a clk edge.
    assign in_frame  = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
    assign cmd_ready = init_done && (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign spi_sel   = !in_frame;
    assign spi_sck   = sck_lvl;
    assign spi_mosi  = ((state == ST_SETUP) || (state == ST_SHIFT)) && shreg[N-1];
    assign poll_due  = init_done && poll_en && (poll_pend || (poll_cnt <= PW'(1)));

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk   (clk),
        .rst_n (rst),
        .en    (state == ST_SHIFT),
        .clr   (state != ST_SHIFT),
        .rise  (sck_rise),
        .fall  (sck_fall),
        .sck   (sck_lvl)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, otherwise paths
    // that skip an assignment would infer latches.
    always_comb begin
        state_nxt  = state;
        start_host = 1'b0;
        start_poll = 1'b0;
        hold_done  = 1'b0;
        gap_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    start_host = 1'b1;
                    state_nxt  = ST_SETUP;
                end else if (poll_due) begin
                    start_poll = 1'b1;
                    state_nxt  = ST_SETUP;
                end
            end
            ST_SETUP: if (tmr == HALF_LAST) state_nxt = ST_SHIFT;
            ST_SHIFT: if (sck_fall && (bit_cnt == BW'(N))) state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (tmr == HALF_LAST) begin
                    hold_done = 1'b1;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tmr == GAP_LAST) begin
                    gap_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_done   <= 1'b0;
            tmr         <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            rx          <= '0;
            kind        <= FRAME_HOST;
            reply_valid <= 1'b0;
            reply_data  <= '0;
            ev_valid    <= 1'b0;
            ev_code     <= '0;
            poll_cnt    <= '0;
            poll_pend   <= 1'b0;
        end else begin
            init_done   <= 1'b1;
            reply_valid <= 1'b0;
            ev_valid    <= 1'b0;

            if ((state_nxt != state) || (state == ST_IDLE) || (state == ST_SHIFT))
                tmr <= '0;
            else
                tmr <= tmr + 1'b1;

            if (start_host) begin
                shreg <= {cmd_addr, cmd_data};
                kind  <= FRAME_HOST;
            end else if (start_poll) begin
                shreg <= {ADR_WIDTH'(POLL_ADDR), COMM_WIDTH'(0)};
                kind  <= FRAME_POLL;
            end else if (sck_fall) begin
                shreg <= shreg << 1;
            end

            // Only the leading REPLY_WIDTH miso bits form the reply.
            if (start_host || start_poll) begin
                bit_cnt <= '0;
                rx      <= '0;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt < BW'(REPLY_WIDTH))
                    rx <= (rx << 1) | REPLY_WIDTH'(spi_miso);
            end

            if (hold_done) begin
                if (kind == FRAME_HOST) begin
                    reply_data  <= rx;
                    reply_valid <= 1'b1;
                end else if (rx != '0) begin
                    ev_code  <= rx;
                    ev_valid <= 1'b1;
                end
            end

            // A poll that loses arbitration to a command stays pending so it
            // runs right after that command's gap.
            if (!poll_en) begin
                poll_cnt  <= POLL_RELOAD;
                poll_pend <= 1'b0;
            end else if (gap_done) begin
                poll_cnt <= POLL_RELOAD;
            end else if ((state == ST_IDLE) && init_done) begin
                if (start_poll)
                    poll_pend <= 1'b0;
                else if (start_host && poll_due)
                    poll_pend <= 1'b1;
                if (poll_cnt > PW'(1))
                    poll_cnt <= poll_cnt - 1'b1;
            end
        end
    end

endmodule
